// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter slice.
package multiplier_pkg;

  // Control states of the arbiter FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/Multiplier.sv
// Shared unsigned multiplier datapath: exact DATA_WIDTH x DATA_WIDTH product.
module Multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int PW = 2 * DATA_WIDTH;

  // Widen both operands first so no bits of the product are lost
  always_comb begin
    product = PW'(a) * PW'(b);
  end

endmodule

// File: rtl/multiplier_arbiter_checker.sv
// Protocol properties of the arbiter outputs, kept apart from the design logic.
module multiplier_arbiter_checker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int PW      = 32
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               resp_valid,
  input logic               resp_ready,
  input logic [ID_W-1:0]    resp_id,
  input logic [PW-1:0]      resp_product
);

  // At most one requester is accepted in any cycle
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  // A stalled response stays put until it is consumed
  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=>
      (resp_valid && $stable(resp_id) && $stable(resp_product)));

  // No new request is taken while the response is stalled
  a_no_accept_stalled: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |-> (req_ready == '0));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past last_grant and wraps.
module rr_arbiter
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int          pos;
  int          sum;
  logic        found;
  logic [ID_W-1:0] cand;

  // Walk requesters in priority order and keep the first one that is valid
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    pos       = 0;
    sum       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum  = int'(last_grant) + i;
      pos  = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      cand = ID_W'(pos);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin front end that time-shares one Multiplier among NUM_REQ clients.
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [2*DATA_WIDTH-1:0]       resp_product
);

  localparam int PW = 2 * DATA_WIDTH;

  state_t              state;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [ID_W-1:0]     id_reg;
  logic [ID_W-1:0]     last_grant;
  logic [PW-1:0]       product_reg;
  logic [ID_W-1:0]     resp_id_reg;
  logic                resp_valid_reg;
  logic [PW-1:0]       mul_out;
  logic                arb_enable;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  logic [DATA_WIDTH-1:0] a_lane [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_lane [NUM_REQ];

  // Split the packed operand buses into per-requester lanes
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign a_lane[k] = req_a[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_lane[k] = req_b[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant only when the datapath is free, or the held product leaves this cycle
  always_comb begin
    arb_enable = 1'b0;
    if (rst) begin
      arb_enable = 1'b0;
    end else begin
      case (state)
        IDLE:    arb_enable = 1'b1;
        RESP:    arb_enable = resp_ready;
        default: arb_enable = 1'b0;
      endcase
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  Multiplier #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .a       (a_reg),
    .b       (b_reg),
    .product (mul_out)
  );

  // Capture the winner's operands and id, and move the priority pointer to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      a_reg      <= a_lane[grant_idx];
      b_reg      <= b_lane[grant_idx];
      id_reg     <= grant_idx;
      last_grant <= grant_idx;
    end else begin
      a_reg      <= a_reg;
      b_reg      <= b_reg;
      id_reg     <= id_reg;
      last_grant <= last_grant;
    end
  end

  // Control FSM; the response registers only change when a product is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      product_reg    <= '0;
      resp_id_reg    <= '0;
      resp_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          product_reg    <= mul_out;
          resp_id_reg    <= id_reg;
          resp_valid_reg <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            if (accept) begin
              state <= MUL;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= RESP;
          end
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid   = resp_valid_reg;
  assign resp_id      = resp_id_reg;
  assign resp_product = product_reg;

  multiplier_arbiter_checker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .PW      (PW)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product)
  );

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized and directed bench for multiplier_arbiter with a transaction-level model.
module tb_multiplier_arbiter;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*DW-1:0]   resp_product;

  always #5 clk = ~clk;

  multiplier_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side: pending flag and operands held until accepted
  bit           pend [N];
  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];

  // Reference model: priority pointer, job being multiplied, job waiting to leave
  int           last_m;
  int           phase_m;      // 0 free, 1 multiplying, 2 response waiting
  int           cur_id, hold_id;
  logic [31:0]  cur_prod, hold_prod;
  int           dut_grants[$];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic reset_model();
    last_m  = N - 1;
    phase_m = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = pend[k];
      req_a[k*DW +: DW]     = op_a[k];
      req_b[k*DW +: DW]     = op_b[k];
    end
  endtask

  function automatic logic [DW-1:0] rand_op();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return 16'hFFFF;
    if (sel == 1) return 16'h0000;
    return DW'($urandom);
  endfunction

  // Re-arm idle requesters; prob_pct is the chance each idle one raises a request
  task automatic refill(input int prob_pct);
    for (int k = 0; k < N; k++) begin
      if (!pend[k]) begin
        op_a[k] = rand_op();
        op_b[k] = rand_op();
        if ($urandom_range(0, 99) < prob_pct) pend[k] = 1'b1;
      end
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int w, nxt;
    drive();
    @(negedge clk);
    w = rr_pick(req_valid, last_m);
    exp_ready = '0;
    if (w >= 0 && (phase_m == 0 || (phase_m == 2 && resp_ready))) exp_ready[w] = 1'b1;
    check_value("req_ready", 64'(req_ready), 64'(exp_ready));
    check_value("resp_valid", 64'(resp_valid), 64'(phase_m == 2));
    if (phase_m == 2) begin
      check_value("resp_id", 64'(resp_id), 64'(hold_id));
      check_value("resp_product", 64'(resp_product), 64'(hold_prod));
    end
    for (int k = 0; k < N; k++) if (req_ready[k]) dut_grants.push_back(k);
    @(posedge clk);
    nxt = phase_m;
    if (phase_m == 1) begin
      hold_id   = cur_id;
      hold_prod = cur_prod;
      nxt       = 2;
    end
    if (phase_m == 2 && resp_ready) nxt = 0;
    if (exp_ready != '0) begin
      cur_id   = w;
      cur_prod = 32'(op_a[w]) * 32'(op_b[w]);
      last_m   = w;
      pend[w]  = 1'b0;
      nxt      = 1;
    end
    phase_m = nxt;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    #1;
    check_value("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_value("rst_req_ready", 64'(req_ready), 64'd0);
    check_value("rst_resp_id", 64'(resp_id), 64'd0);
    check_value("rst_resp_product", 64'(resp_product), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_order [5];
    logic [IDW-1:0]  sid;
    logic [2*DW-1:0] sprod;
    int guard;
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    resp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      op_a[k] = '0;
      op_b[k] = '0;
    end
    drive();
    #2;
    do_reset();

    // Single request from requester 2: 3 * 5
    resp_ready = 1'b1;
    pend[2] = 1'b1; op_a[2] = 16'd3; op_b[2] = 16'd5;
    drive(); #1;
    check_value("t1_first_ready", 64'(req_ready), 64'h4);
    cycle();
    check_value("t1_mul_no_resp", 64'(resp_valid), 64'd0);
    cycle();
    check_value("t1_resp_valid", 64'(resp_valid), 64'd1);
    check_value("t1_resp_id", 64'(resp_id), 64'd2);
    check_value("t1_resp_product", 64'(resp_product), 64'd15);
    cycle();
    check_value("t1_back_idle", 64'(resp_valid), 64'd0);

    // Largest operands
    pend[1] = 1'b1; op_a[1] = 16'hFFFF; op_b[1] = 16'hFFFF;
    cycle(); cycle();
    check_value("max_id", 64'(resp_id), 64'd1);
    check_value("max_product", 64'(resp_product), 64'hFFFE0001);
    cycle();

    // All requesters continuously pending after reset
    do_reset();
    dut_grants.delete();
    resp_ready = 1'b1;
    refill(100);
    for (int c = 0; c < 9; c++) begin
      cycle();
      refill(100);
    end
    check_value("rr_count", 64'(dut_grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < dut_grants.size(); i++)
      check_value("rr_order", 64'(dut_grants[i]), 64'(exp_order[i]));

    // Back-pressure while requests keep coming
    resp_ready = 1'b0;
    guard = 0;
    while (phase_m != 2 && guard < 4) begin
      cycle();
      refill(100);
      guard++;
    end
    check_value("bp_reached_resp", 64'(resp_valid), 64'd1);
    sid = resp_id;
    sprod = resp_product;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check_value("bp_id_stable", 64'(resp_id), 64'(sid));
      check_value("bp_prod_stable", 64'(resp_product), 64'(sprod));
    end
    resp_ready = 1'b1;
    drive(); #1;
    check_value("bp_regrant_same_cycle", 64'(req_ready != '0), 64'd1);
    cycle();
    check_value("bp_completed", 64'(resp_valid), 64'd0);

    // Fairness: serve requester 1, then 0 and 1 compete
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    do_reset();
    dut_grants.delete();
    pend[1] = 1'b1; op_a[1] = 16'd9; op_b[1] = 16'd11;
    cycle();
    pend[0] = 1'b1; op_a[0] = 16'd100; op_b[0] = 16'd200;
    pend[1] = 1'b1; op_a[1] = 16'd7;   op_b[1] = 16'd6;
    cycle(); cycle();
    check_value("fair_count", 64'(dut_grants.size()), 64'd2);
    if (dut_grants.size() >= 2) check_value("fair_next", 64'(dut_grants[1]), 64'd0);
    for (int c = 0; c < 6; c++) cycle();

    // Reset while a product is being computed
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    pend[3] = 1'b1; op_a[3] = 16'd7; op_b[3] = 16'd9;
    cycle();
    check_value("abort_in_mul", 64'(resp_valid), 64'd0);
    pend[0] = 1'b1; pend[1] = 1'b1; pend[2] = 1'b1; pend[3] = 1'b1;
    drive();
    rst = 1'b1;
    reset_model();
    #1;
    check_value("abort_resp_valid", 64'(resp_valid), 64'd0);
    check_value("abort_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(); #1;
    check_value("abort_tie_to_0", 64'(req_ready), 64'h1);
    for (int c = 0; c < 8; c++) cycle();

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 1500; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      refill(40);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Shares one combinational `Multiplier` datapath (DATA_WIDTH × DATA_WIDTH → 2·DATA_WIDTH) between NUM_REQ requesters. Each requester uses a valid/ready request channel. The block grants one requester at a time using round-robin priority, registers the operands into the multiplier, and registers the product. It returns the product on a single response channel tagged with the requester id, and sits between client engines and the shared multiplier instance.

## Interface
- DATA_WIDTH, 16, operand width; product is 2·DATA_WIDTH
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, $clog2(NUM_REQ), response id width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ·DATA_WIDTH  operand A, requester k at bits [k·DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ·DATA_WIDTH  operand B, same packing
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_id  out  ID_W  index of requester that owns the product
- resp_product  out  2·DATA_WIDTH  unsigned product A·B

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE: if any req_valid, assert req_ready for the round-robin winner only.
  - Handshake (valid & ready) latches a_reg, b_reg and id_reg, updates the priority pointer to the winner, and moves to MUL.
- MUL: the Multiplier output is a function of a_reg/b_reg. The edge latches product_reg and moves to RESP.
- RESP: resp_valid = 1. resp_id and resp_product are held stable until resp_ready.
  - resp_ready = 1 with no req_valid: go to IDLE.
  - resp_ready = 1 with some req_valid: grant a new winner in the same cycle (req_ready may assert while resp_valid & resp_ready), latch the new operands, and go to MUL.
  - resp_ready = 0: req_ready stays 0.
- Round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ. A requester that was just served has lowest priority for the next grant.
- Arithmetic: unsigned. The product is exact in 2·DATA_WIDTH bits, with no truncation or saturation.
  - Maximum case: (2^DW−1)² = 2^(2DW) − 2^(DW+1) + 1.
- Requesters hold valid and operands stable until they see ready. Deasserting valid before the handshake is a protocol violation, and the block need not detect it.
- Operands of non-granted requesters are ignored.

## Timing
- Reset values:
  - state = IDLE
  - req_ready = 0
  - resp_valid = 0
  - resp_id = 0
  - resp_product = 0
  - last_grant = NUM_REQ−1, so requester 0 has highest priority after reset
- req_ready is combinational from req_valid, state, resp_ready and last_grant. It has no combinational dependency on req_a or req_b.
- Latency: request handshake at edge E0, product_reg loaded at E1, resp_valid high from E1 onward. That is two edges from accept to response-visible.
- Throughput: one product every 2 cycles when resp_ready is held high and requests are continuously pending.
- Back-pressure: resp_ready low holds RESP indefinitely. Outputs are stable, and no request is accepted.
- Reset mid-operation: any in-flight product is discarded. Outputs go to reset values immediately (asynchronous), and the pointer returns to its reset value.
- Simultaneous requests: exactly one req_ready bit is set per cycle. The other requesters are not accepted.

## Structure
- Shared package multiplier_pkg:
  - state enum {IDLE, MUL, RESP}
  - id width helper based on $clog2
- Sub-module rr_arbiter:
  - params NUM_REQ
  - inputs: request vector, last_grant, enable
  - outputs: one-hot grant and encoded index
  - purely combinational
- Existing Multiplier instance, #(DATA_WIDTH), fed from a_reg/b_reg. It is the only datapath, and product_reg samples its output.
- The top level holds the FSM, the operand, id and product registers, and the pointer register.

## Test plan
- Single request: reset, then requester 2 presents A=3, B=5 with resp_ready=1. Expect req_ready[2] in the first IDLE cycle, resp_valid 2 edges later with resp_id=2 and resp_product=15, then return to IDLE.
- Max operands (DW=16): A=B=0xFFFF. Expect product 0xFFFE0001.
- All four requesters valid continuously with resp_ready=1. Expect grants in order 0,1,2,3,0, with back-to-back accept in RESP (one response every 2 cycles).
- Back-pressure: hold resp_ready=0 for 5 cycles during RESP. Expect resp_id/resp_product stable, all req_ready=0, and completion on the first cycle resp_ready=1.
- Fairness: requester 1 served, then requesters 0 and 1 both valid. Expect grant to 0 next, not 1.
- Assert rst while in MUL. Expect resp_valid=0 immediately and no response for the aborted request. After release, requester 0 wins ties.
